// File: rtl/mux8_cfg_pkg.sv
// Shared definitions for the MUX8LUT configuration sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux8_cfg_pkg;

    // Upper bound on controllable slices; the index field is sized to address all of them.
    localparam int MAX_MUX    = 16;
    localparam int IDX_W      = $clog2(MAX_MUX);

    // Field positions inside the 32-bit configuration word.
    localparam int IDX_LSB    = 0;
    localparam int MODE_LSB   = 4;
    localparam int COMMIT_BIT = 31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } cfg_state_t;

endpackage

// File: rtl/mux8_cfg_shadow.sv
// Shadow register bank: one MODE_W-bit entry per slice, written one slot at a time.
// Latency: a write is visible on shadow_bits the cycle after wr_en.
// Backpressure: none; writes to slots >= NUM_MUX are dropped.
module mux8_cfg_shadow
    import mux8_cfg_pkg::*;
#(
    parameter int NUM_MUX = 8,
    parameter int MODE_W  = 2
) (
    input  logic                      CLK,
    input  logic                      resetn,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [MODE_W-1:0]         wr_mode,
    output logic [NUM_MUX*MODE_W-1:0] shadow_bits
);

    // Update only the addressed slot; an unmatched index touches nothing.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            shadow_bits <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_MUX; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    shadow_bits[i*MODE_W +: MODE_W] <= wr_mode;
                end
            end
        end
    end

endmodule

// File: rtl/mux8_cfg_sequencer.sv
// Collects per-slice config words into a shadow bank and commits them atomically to ConfigBits.
// Latency: ConfigBits and cfg_update change 2 cycles after the commit-word handshake.
// Backpressure: s_ready drops for exactly the one COMMIT cycle; optional readback via MUX8_CFG_READBACK_EN.
module mux8_cfg_sequencer
    import mux8_cfg_pkg::*;
#(
    parameter int NUM_MUX = 8,
    parameter int MODE_W  = 2
) (
    input  logic                      CLK,
    input  logic                      resetn,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [31:0]               s_data,
    output logic [NUM_MUX*MODE_W-1:0] ConfigBits,
    output logic                      cfg_update,
    output logic                      busy,
    output logic                      err,
`ifdef MUX8_CFG_READBACK_EN
    input  logic [IDX_W-1:0]          rb_idx,
    output logic [MODE_W-1:0]         rb_data,
`endif
    input  logic                      err_clr
);

    // One extra bit so NUM_MUX = MAX_MUX is representable in the range compare.
    localparam logic [IDX_W:0] NUM_MUX_L = (IDX_W+1)'(NUM_MUX);

    cfg_state_t                  state;
    logic                        xfer;
    logic                        idx_ok;
    logic                        is_commit;
    logic [IDX_W-1:0]            w_idx;
    logic [MODE_W-1:0]           w_mode;
    logic [NUM_MUX*MODE_W-1:0]   shadow_bits;
    logic                        unused_data;

    assign w_idx       = s_data[IDX_LSB +: IDX_W];
    assign w_mode      = s_data[MODE_LSB +: MODE_W];
    assign is_commit   = s_data[COMMIT_BIT];
    assign unused_data = ^s_data[COMMIT_BIT-1 : MODE_LSB+MODE_W];
    assign xfer        = s_valid & s_ready;
    assign idx_ok      = ({1'b0, w_idx} < NUM_MUX_L);

    mux8_cfg_shadow #(
        .NUM_MUX (NUM_MUX),
        .MODE_W  (MODE_W)
    ) u_shadow (
        .CLK         (CLK),
        .resetn      (resetn),
        .wr_en       (xfer & idx_ok),
        .wr_idx      (w_idx),
        .wr_mode     (w_mode),
        .shadow_bits (shadow_bits)
    );

    // Sequencer FSM; s_ready/busy are registered from the next state so they never glitch.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            cfg_update <= 1'b0;
            ConfigBits <= '0;
        end else begin
            cfg_update <= 1'b0;
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    s_ready <= 1'b1;
                    busy    <= (state == ST_COLLECT) | xfer;
                    if (xfer) begin
                        if (is_commit) begin
                            state   <= ST_COMMIT;
                            s_ready <= 1'b0;
                        end else begin
                            state   <= ST_COLLECT;
                        end
                    end
                end
                ST_COMMIT: begin
                    ConfigBits <= shadow_bits;
                    cfg_update <= 1'b1;
                    state      <= ST_IDLE;
                    s_ready    <= 1'b1;
                    busy       <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error: a fresh out-of-range write wins over a same-cycle clear.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else begin
            err <= (err & ~err_clr) | (xfer & ~idx_ok);
        end
    end

`ifdef MUX8_CFG_READBACK_EN
    // Combinational readback of the active config; unmapped indices read as zero.
    always_comb begin
        rb_data = '0;
        for (int i = 0; i < NUM_MUX; i++) begin
            if (rb_idx == IDX_W'(i)) begin
                rb_data = ConfigBits[i*MODE_W +: MODE_W];
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux8_cfg_sequencer.sv
// Self-checking bench for mux8_cfg_sequencer against a slot-array reference model.
// Latency: model applies a commit one clock after the commit handshake edge.
// Backpressure: model expects s_ready low only in the cycle following an accepted commit word.
module tb_mux8_cfg_sequencer;

    localparam int NUM_MUX = 8;
    localparam int MODE_W  = 2;
    localparam int CW      = NUM_MUX * MODE_W;

    logic          CLK = 1'b0;
    logic          resetn;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_data;
    logic [CW-1:0] ConfigBits;
    logic          cfg_update;
    logic          busy;
    logic          err;
    logic          err_clr;
`ifdef MUX8_CFG_READBACK_EN
    logic [3:0]        rb_idx;
    logic [MODE_W-1:0] rb_data;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: pending slot values, active slot values, and status flags.
    logic [MODE_W-1:0] shadow_m [NUM_MUX];
    logic [MODE_W-1:0] cfg_m    [NUM_MUX];
    logic err_m, exp_rdy, exp_upd, pending, dirty;

    always #5 CLK = ~CLK;

    mux8_cfg_sequencer #(
        .NUM_MUX (NUM_MUX),
        .MODE_W  (MODE_W)
    ) dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .ConfigBits (ConfigBits),
        .cfg_update (cfg_update),
        .busy       (busy),
        .err        (err),
`ifdef MUX8_CFG_READBACK_EN
        .rb_idx     (rb_idx),
        .rb_data    (rb_data),
`endif
        .err_clr    (err_clr)
    );

    function automatic logic [CW-1:0] exp_cfg();
        logic [CW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_MUX; i++) v[i*MODE_W +: MODE_W] = cfg_m[i];
        return v;
    endfunction

    function automatic logic [31:0] word(input int idx, input int mode, input logic commit);
        logic [31:0] w;
        w = '0;
        w[3:0]  = 4'(idx);
        w[5:4]  = 2'(mode);
        w[31]   = commit;
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_MUX; i++) begin
            shadow_m[i] = '0;
            cfg_m[i]    = '0;
        end
        err_m   = 1'b0;
        exp_rdy = 1'b0;
        exp_upd = 1'b0;
        pending = 1'b0;
        dirty   = 1'b0;
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
    task automatic cycle(input logic vld, input logic [31:0] dat, input logic clr, output logic hs);
        int idx;
        s_valid = vld;
        s_data  = dat;
        err_clr = clr;
        hs      = vld && s_ready;
        idx     = int'(dat[3:0]);
        @(posedge CLK);
        exp_upd = 1'b0;
        if (pending) begin
            for (int i = 0; i < NUM_MUX; i++) cfg_m[i] = shadow_m[i];
            exp_upd = 1'b1;
            pending = 1'b0;
            dirty   = 1'b0;
        end
        err_m   = (err_m && !clr) || (hs && idx >= NUM_MUX);
        exp_rdy = 1'b1;
        if (hs) begin
            if (idx < NUM_MUX) shadow_m[idx] = dat[5:4];
            dirty = 1'b1;
            if (dat[31]) begin
                pending = 1'b1;
                exp_rdy = 1'b0;
            end
        end
        @(negedge CLK);
        s_valid = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic apply_reset();
        logic hs;
        @(negedge CLK);
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        err_clr = 1'b0;
        model_reset();
        @(negedge CLK);
        resetn = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, hs);
    endtask

    task automatic test_reset();
        logic hs;
        resetn = 1'b0; s_valid = 1'b0; s_data = '0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        checks++;
        if ({s_ready, cfg_update, busy, err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got rdy/upd/busy/err=%b required 0000", {s_ready, cfg_update, busy, err});
        end
        checks++;
        if (ConfigBits !== '0) begin
            errors++;
            $display("FAIL reset_cfg got %h required 0000", ConfigBits);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_rdy got %b required 0 before first edge", s_ready);
        end
        @(negedge CLK);
        cycle(1'b0, 32'h0, 1'b0, hs);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_edge_rdy got %b required 1", s_ready);
        end
    endtask

    task automatic test_single_commit();
        logic hs;
        apply_reset();
        cycle(1'b1, word(2, 3, 1'b1), 1'b0, hs);
        checks++;
        if (hs !== 1'b1) begin errors++; $display("FAIL single_hs got %b required 1", hs); end
        checks++;
        if ({s_ready, cfg_update, busy} !== 3'b001 || ConfigBits !== 16'h0000) begin
            errors++;
            $display("FAIL single_commit_cycle got rdy/upd/busy=%b cfg=%h required 001 cfg=0000", {s_ready, cfg_update, busy}, ConfigBits);
        end
        cycle(1'b0, 32'h0, 1'b0, hs);
        checks++;
        if (cfg_update !== 1'b1 || ConfigBits !== 16'h0030) begin
            errors++;
            $display("FAIL single_update got upd=%b cfg=%h required upd=1 cfg=0030", cfg_update, ConfigBits);
        end
        cycle(1'b0, 32'h0, 1'b0, hs);
        checks++;
        if (cfg_update !== 1'b0 || busy !== 1'b0 || ConfigBits !== 16'h0030) begin
            errors++;
            $display("FAIL single_after got upd=%b busy=%b cfg=%h required 0 0 0030", cfg_update, busy, ConfigBits);
        end
    endtask

    task automatic test_multi_write();
        logic hs;
        apply_reset();
        cycle(1'b1, word(0, 1, 1'b0), 1'b0, hs);
        cycle(1'b1, word(7, 2, 1'b0), 1'b0, hs);
        checks++;
        if (ConfigBits !== 16'h0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL multi_collect got cfg=%h busy=%b required 0000 1", ConfigBits, busy);
        end
        cycle(1'b1, word(1, 3, 1'b1), 1'b0, hs);
        checks++;
        if (ConfigBits !== 16'h0000 || cfg_update !== 1'b0) begin
            errors++;
            $display("FAIL multi_in_commit got cfg=%h upd=%b required 0000 0", ConfigBits, cfg_update);
        end
        cycle(1'b0, 32'h0, 1'b0, hs);
        checks++;
        if (ConfigBits !== 16'h800D || cfg_update !== 1'b1) begin
            errors++;
            $display("FAIL multi_result got cfg=%h upd=%b required 800d 1", ConfigBits, cfg_update);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic hs;
        int n_commit = 0;
        int low_seen = 0;
        int budget   = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            q.push_back(word($urandom_range(0, 7), $urandom_range(0, 3), (i % 3) != 1));
            if ((i % 3) != 1) n_commit++;
        end
        while (q.size() > 0 && budget < 60) begin
            cycle(1'b1, q[0], 1'b0, hs);
            if (hs) void'(q.pop_front());
            budget++;
            if (s_ready === 1'b0) low_seen++;
            checks++;
            if (s_ready !== exp_rdy || ConfigBits !== exp_cfg() || cfg_update !== exp_upd) begin
                errors++;
                $display("FAIL b2b_cycle got rdy=%b cfg=%h upd=%b required rdy=%b cfg=%h upd=%b",
                         s_ready, ConfigBits, cfg_update, exp_rdy, exp_cfg(), exp_upd);
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain got %0d words left required 0", q.size());
        end
        checks++;
        if (low_seen != n_commit) begin
            errors++;
            $display("FAIL b2b_ready_low got %0d low cycles required %0d", low_seen, n_commit);
        end
        cycle(1'b0, 32'h0, 1'b0, hs);
        checks++;
        if (ConfigBits !== exp_cfg()) begin
            errors++;
            $display("FAIL b2b_final got cfg=%h required %h", ConfigBits, exp_cfg());
        end
    endtask

    task automatic test_err();
        logic hs;
        apply_reset();
        cycle(1'b1, word(4, 2, 1'b1), 1'b0, hs);
        repeat (2) cycle(1'b0, 32'h0, 1'b0, hs);
        cycle(1'b1, word(9, 1, 1'b1) | 32'h5555_5540, 1'b0, hs);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b required 1", err); end
        cycle(1'b0, 32'h0, 1'b0, hs);
        checks++;
        if (ConfigBits !== 16'h0200 || cfg_update !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL err_commit got cfg=%h upd=%b err=%b required 0200 1 1", ConfigBits, cfg_update, err);
        end
        cycle(1'b0, 32'h0, 1'b1, hs);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b required 0", err); end
        cycle(1'b1, word(12, 0, 1'b0), 1'b0, hs);
        cycle(1'b1, word(15, 0, 1'b1), 1'b1, hs);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_clr_collide got %b required 1", err); end
        repeat (2) cycle(1'b0, 32'h0, 1'b0, hs);
        checks++;
        if (ConfigBits !== 16'h0200 || err !== 1'b1) begin
            errors++;
            $display("FAIL err_unchanged got cfg=%h err=%b required 0200 1", ConfigBits, err);
        end
    endtask

    task automatic test_reset_mid_collect();
        logic hs;
        int upd_seen = 0;
        apply_reset();
        cycle(1'b1, word(3, 2, 1'b0), 1'b0, hs);
        cycle(1'b1, word(6, 1, 1'b0), 1'b0, hs);
        resetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({s_ready, cfg_update, busy, err} !== 4'b0000 || ConfigBits !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got rdy/upd/busy/err=%b cfg=%h required 0000 0000",
                     {s_ready, cfg_update, busy, err}, ConfigBits);
        end
        repeat (2) begin
            @(negedge CLK);
            if (cfg_update !== 1'b0) upd_seen++;
        end
        resetn = 1'b1;
        repeat (2) begin
            cycle(1'b0, 32'h0, 1'b0, hs);
            if (cfg_update !== 1'b0) upd_seen++;
        end
        checks++;
        if (upd_seen != 0) begin errors++; $display("FAIL midreset_no_update got %0d pulses required 0", upd_seen); end
        cycle(1'b1, word(0, 0, 1'b1), 1'b0, hs);
        cycle(1'b0, 32'h0, 1'b0, hs);
        checks++;
        if (ConfigBits !== 16'h0000 || cfg_update !== 1'b1) begin
            errors++;
            $display("FAIL midreset_empty_commit got cfg=%h upd=%b required 0000 1", ConfigBits, cfg_update);
        end
    endtask

    task automatic test_random();
        logic hs;
        logic [31:0] d;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            d     = $urandom;
            d[31] = ($urandom_range(0, 3) == 0);
            cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 15) == 0, hs);
            checks++;
            if (s_ready !== exp_rdy || ConfigBits !== exp_cfg() || cfg_update !== exp_upd ||
                err !== err_m || busy !== (dirty || pending)) begin
                errors++;
                $display("FAIL random_cycle %0d got rdy=%b cfg=%h upd=%b err=%b busy=%b required rdy=%b cfg=%h upd=%b err=%b busy=%b",
                         n, s_ready, ConfigBits, cfg_update, err, busy,
                         exp_rdy, exp_cfg(), exp_upd, err_m, dirty || pending);
            end
        end
    endtask

`ifdef MUX8_CFG_READBACK_EN
    task automatic test_readback();
        logic hs;
        apply_reset();
        cycle(1'b1, word(5, 1, 1'b1), 1'b0, hs);
        repeat (2) cycle(1'b0, 32'h0, 1'b0, hs);
        rb_idx = 4'd5;
        #1;
        checks++;
        if (rb_data !== 2'b01) begin errors++; $display("FAIL readback_idx5 got %b required 01", rb_data); end
        rb_idx = 4'd12;
        #1;
        checks++;
        if (rb_data !== 2'b00) begin errors++; $display("FAIL readback_idx12 got %b required 00", rb_data); end
    endtask
`endif

    initial begin
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        err_clr = 1'b0;
`ifdef MUX8_CFG_READBACK_EN
        rb_idx  = '0;
`endif
        test_reset();
        test_single_commit();
        test_multi_write();
        test_back_to_back();
        test_err();
        test_reset_mid_collect();
        test_random();
`ifdef MUX8_CFG_READBACK_EN
        test_readback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
